// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Responder side of the data-memory request interface. One load or store
// (RV32 func3 encoding: LB/LH/LW/LBU/LHU, SB/SH/SW) is accepted at a time,
// performed on an internal word-organised array on the accepting edge, and
// answered with one response LATENCY cycles later.
//
// Handshakes: a request transfers on a rising edge where req_valid=1 and
// req_ready=1 (req_ready is registered and high only in IDLE). A response
// transfers on a rising edge where resp_valid=1 and resp_ready=1; while
// resp_ready=0 the response (resp_rdata, resp_err) is held stable.
//
// Optional feature macro: DMEM_MISALIGN_ERR_EN
//   defined   : misaligned halfword/word accesses report resp_err=1, no write.
//   undefined : the address is aligned down to the access size instead.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_func3             access size/sign
//   req_addr              byte address
//   req_wdata             store data (low byte/half used for SB/SH)
//   resp_valid/resp_ready response handshake
//   resp_rdata            extended load data; 0 for stores and errors
//   resp_err              range, func3 or (optionally) alignment error
//   dbgState              current FSM state (0=IDLE, 1=WAIT, 2=RESP)
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_func3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [1:0]            dbgState
);

   localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int WIDX_W = ADDR_WIDTH - 2;
   localparam int CNT_W  = $clog2(LATENCY + 1);
   localparam logic [WIDX_W-1:0] DEPTH_LIMIT = WIDX_W'(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } stateT;

   stateT                 state;
   logic [CNT_W-1:0]      count;
   logic [DATA_WIDTH-1:0] rdataHold;
   logic                  errHold;

   // Zero at time 0 only; reset deliberately leaves the contents alone.
   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS] = '{default: '0};

   logic [WIDX_W-1:0]     wordIdx;
   logic [IDX_W-1:0]      memIdx;
   logic                  isHalf;
   logic                  isWord;
   logic                  funcErr;
   logic                  rangeErr;
   logic                  alignErr;
   logic                  reqErr;
   logic [1:0]            laneOff;
   logic [DATA_WIDTH-1:0] readWord;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] loadData;
   logic [DATA_WIDTH-1:0] respData;
   logic [DATA_WIDTH-1:0] storeData;
   logic [3:0]            byteEn;
   logic                  accept;

   assign dbgState = state;
   assign accept   = (state == IDLE) && req_valid;

   assign wordIdx  = req_addr[ADDR_WIDTH-1:2];
   assign memIdx   = wordIdx[IDX_W-1:0];
   assign isHalf   = (req_func3[1:0] == 2'b01);
   assign isWord   = (req_func3[1:0] == 2'b10);
   assign rangeErr = (wordIdx >= DEPTH_LIMIT);

   // Loads allow 0,1,2,4,5; stores allow 0,1,2.
   assign funcErr  = req_write ? (req_func3 >= 3'd3)
                               : ((req_func3 == 3'd3) || (req_func3[2:1] == 2'b11));

`ifdef DMEM_MISALIGN_ERR_EN
   assign alignErr = (isHalf && req_addr[0]) || (isWord && (req_addr[1:0] != 2'b00));
`else
   assign alignErr = 1'b0;
`endif

   assign reqErr = funcErr || rangeErr || alignErr;

   // Lane offset aligned down to the access size. With the alignment check
   // enabled, misaligned cases are already errors, so this is harmless there.
   always_comb begin
      laneOff = req_addr[1:0];
      if (isHalf) laneOff[0] = 1'b0;
      if (isWord) laneOff    = 2'b00;
   end

   assign readWord = mem[memIdx];
   assign shifted  = readWord >> {laneOff, 3'b000};

   always_comb begin
      loadData = '0;
      case (req_func3)
         3'd0:    loadData = {{24{shifted[7]}}, shifted[7:0]};
         3'd1:    loadData = {{16{shifted[15]}}, shifted[15:0]};
         3'd2:    loadData = readWord;
         3'd4:    loadData = {24'b0, shifted[7:0]};
         3'd5:    loadData = {16'b0, shifted[15:0]};
         default: loadData = '0;
      endcase
   end

   assign respData = (req_write || reqErr) ? '0 : loadData;

   // Store data is replicated across lanes so the byte enables pick it up.
   always_comb begin
      storeData = req_wdata;
      byteEn    = 4'b1111;
      if (req_func3[1:0] == 2'b00) begin
         storeData = {4{req_wdata[7:0]}};
         byteEn    = 4'b0001 << laneOff;
      end else if (isHalf) begin
         storeData = {2{req_wdata[15:0]}};
         byteEn    = laneOff[1] ? 4'b1100 : 4'b0011;
      end
   end

   // Stores commit on the accepting edge; errored requests write nothing.
   always_ff @(posedge clk) begin
      if (!reset && accept && req_write && !reqErr) begin
         for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) mem[memIdx][8*i +: 8] <= storeData[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         count      <= '0;
         rdataHold  <= '0;
         errHold    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  rdataHold <= respData;
                  errHold   <= reqErr;
                  count     <= CNT_W'(LATENCY - 1);
                  req_ready <= 1'b0;
                  if (LATENCY == 1) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= respData;
                     resp_err   <= reqErr;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (count == CNT_W'(1)) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= rdataHold;
                  resp_err   <= errHold;
                  count      <= '0;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the data-memory request interface that the pipeline controller drives.
- Accepts one load or store request at a time, encoded with RV32 func3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Performs the access on an internal word-organised array and returns one response per request after a fixed latency.
- Responses use a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, data width; fixed at 32 (one word = 4 bytes).
- DEPTH_WORDS, 1024, number of 32-bit words in the array.
- LATENCY, 2, cycles from request acceptance to resp_valid assertion; legal range >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_func3  input  3  access size/sign, RV32 func3 encoding.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data; low byte/half used for SB/SH.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer takes response.
- resp_rdata  output  DATA_WIDTH  load result, already extended; 0 for stores and errors.
- resp_err  output  1  request was misaligned, out of range or had illegal func3.

Behaviour:
- Reset (reset=1 at a clock edge): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
- Reset does not clear the array. The array is zero-initialised at time 0 only.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Acceptance occurs when req_valid=1 at an edge.
  - On acceptance: capture write/func3/addr/wdata, compute the error flag, set counter=LATENCY-1.
  - If LATENCY=1, go directly to RESP; otherwise go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; at 1 → RESP on the next edge.
  - Net result: resp_valid rises exactly LATENCY cycles after the accepting edge.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable while resp_ready=0.
  - On an edge with resp_ready=1 → IDLE; resp_valid, resp_rdata and resp_err drop to 0.
  - req_ready is 0 in RESP. A new request can be accepted at the earliest in the cycle after the handshake.
- Store commit:
  - Byte lanes are written on the accepting edge; only lanes selected by size and addr[1:0] change.
  - SB writes lane addr[1:0]. SH writes lanes {addr[1],0} and {addr[1],1}. SW writes all four lanes.
  - Little-endian: lane 0 = bits 7:0.
  - A later load sees the stored data.
- Load data:
  - The word is read on the accepting edge and extracted by addr[1:0].
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes the word through.
- Word index = addr[ADDR_WIDTH-1:2].
- Error conditions (any one sets resp_err=1):
  - Word index >= DEPTH_WORDS.
  - Load with func3 in {3,6,7}.
  - Store with func3 >= 3.
  - Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0 (see optional feature).
- An errored request writes nothing, returns resp_rdata=0, and still takes the full LATENCY and handshake.
- req_valid during WAIT/RESP is ignored; the requester must hold the request until req_ready=1.
- Reset mid-operation:
  - A pending WAIT/RESP transaction is dropped and no response is produced.
  - A store already accepted remains committed.
- resp_ready=1 with resp_valid=0 has no effect.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined: misaligned halfword/word accesses set resp_err=1, perform no write and return 0.
- Undefined:
  - No misalignment check. The address is aligned down to the access size (halfword ignores addr[0]; word ignores addr[1:0]) and the access proceeds normally.
  - resp_err reflects only the range and func3 errors.

Test Plan:
- After reset, with LATENCY=2, send SW addr=0x10 wdata=0xDEADBEEF. Then send LW addr=0x10 with resp_ready=1 → first response has rdata=0, err=0. LW response has rdata=0xDEADBEEF, and resp_valid rises exactly 2 cycles after acceptance.
- SB addr=0x21 wdata=0x80, then LB 0x21 → 0xFFFFFF80; LBU 0x21 → 0x00000080; LW 0x20 → 0x00008000.
- SH addr=0x32 wdata=0x1234ABCD, then LH 0x32 → 0xFFFFABCD; LHU 0x32 → 0x0000ABCD; LW 0x30 → 0xABCD0000.
- Hold resp_ready=0 for 5 cycles on LW 0x10 → resp_valid stays 1, rdata stays 0xDEADBEEF, req_ready stays 0. Raise resp_ready → resp_valid=0 and req_ready=1 on the next cycle.
- LW addr=0x12 with macro defined → err=1, rdata=0, word at 0x10 unchanged. With macro undefined → rdata=0xDEADBEEF, err=0. LW addr=4*DEPTH_WORDS → err=1. Load with func3=3 → err=1.
- Accept SW 0x40 = 0x55, assert reset during WAIT → no resp_valid. After reset, LW 0x40 → 0x00000055.
